my_cpu_mc_control: RTL

Multi-cycle control unit for the RV32I subset (R-type ALU, I-type ALU, LW, SW, branches, JAL, JALR). It replaces the single-cycle decoder when the datapath shares one memory port between instruction fetch and data access. It sequences fetch, decode, execute, memory and writeback over several cycles, and stalls on the `MIO_ready` handshake. A wait-state counter traps a bus that never answers.

---
 rtl/my_cpu_mc_control.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/my_cpu_mc_control.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// over one shared memory port, with a wait-state timeout that traps a dead bus.
module my_cpu_mc_control #(
    parameter int WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       MIO_ready,
    input  logic       branch_cond,
    output logic       CPU_MIO,
    output logic       MemRW,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrc_A,
    output logic [1:0] ALUSrc_B,
    output logic [1:0] ImmSel,
    output logic [3:0] ALU_Control,
    output logic       RegWrite,
    output logic [1:0] MemtoReg,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_ALU  = 4'd2,
        S_EX_ADR  = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_WB_ALU  = 4'd6,
        S_WB_LD   = 4'd7,
        S_EX_BR   = 4'd8,
        S_EX_JAL  = 4'd9,
        S_EX_JALR = 4'd10,
        S_TRAP    = 4'd11
    } state_t;

    localparam logic [4:0] OP_R    = 5'b01100;
    localparam logic [4:0] OP_I    = 5'b00100;
    localparam logic [4:0] OP_LW   = 5'b00000;
    localparam logic [4:0] OP_SW   = 5'b01000;
    localparam logic [4:0] OP_BR   = 5'b11000;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_JALR = 5'b11001;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t          cur_state;
    state_t          next_state;
    logic [CW-1:0]   wait_cnt;
    logic            timeout;

    assign state = cur_state;

    // The WAIT_MAX-th consecutive wait cycle is the last one tolerated.
    assign timeout = CPU_MIO && !MIO_ready && (wait_cnt == CW'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IF;
        end else begin
            cur_state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if (CPU_MIO && !MIO_ready && (next_state == cur_state)) begin
                if (wait_cnt != CW'(WAIT_MAX)) begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
            if ((cur_state == S_ID) && (next_state == S_TRAP)) begin
                illegal <= 1'b1;
            end
            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = cur_state;
        CPU_MIO     = 1'b0;
        MemRW       = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUSrc_A    = 2'b00;
        ALUSrc_B    = 2'b00;
        ImmSel      = 2'b00;
        ALU_Control = ALU_ADD;
        RegWrite    = 1'b0;
        MemtoReg    = 2'b00;

        case (cur_state)
            S_IF: begin
                CPU_MIO  = 1'b1;
                ALUSrc_B = 2'b10;
                IRWrite  = MIO_ready;
                PCWrite  = MIO_ready;
                if (MIO_ready) begin
                    next_state = S_ID;
                end
            end
            // Branch target is precomputed here so EX_BR can use ALUOut.
            S_ID: begin
                ALUSrc_A = 2'b01;
                ALUSrc_B = 2'b01;
                ImmSel   = 2'b10;
                case (OPcode)
                    OP_R, OP_I:   next_state = S_EX_ALU;
                    OP_LW, OP_SW: next_state = S_EX_ADR;
                    OP_BR:        next_state = S_EX_BR;
                    OP_JAL:       next_state = S_EX_JAL;
                    OP_JALR:      next_state = S_EX_JALR;
                    default:      next_state = S_TRAP;
                endcase
            end
            // Immediate forms only honour Fun7 for shifts, so SUB never appears.
            S_EX_ALU: begin
                ALUSrc_A = 2'b10;
                if (OPcode == OP_R) begin
                    ALUSrc_B    = 2'b00;
                    ALU_Control = {Fun7, Fun3};
                end else begin
                    ALUSrc_B    = 2'b01;
                    ALU_Control = {Fun7 & (Fun3 == 3'b101), Fun3};
                end
                next_state = S_WB_ALU;
            end
            S_WB_ALU: begin
                RegWrite   = 1'b1;
                next_state = S_IF;
            end
            S_EX_ADR: begin
                ALUSrc_A = 2'b10;
                ALUSrc_B = 2'b01;
                if (OPcode == OP_SW) begin
                    ImmSel     = 2'b01;
                    next_state = S_MEM_WR;
                end else begin
                    next_state = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                CPU_MIO = 1'b1;
                IorD    = 1'b1;
                if (MIO_ready) begin
                    next_state = S_WB_LD;
                end
            end
            S_MEM_WR: begin
                CPU_MIO = 1'b1;
                IorD    = 1'b1;
                MemRW   = 1'b1;
                if (MIO_ready) begin
                    next_state = S_IF;
                end
            end
            S_WB_LD: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                next_state = S_IF;
            end
            S_EX_BR: begin
                ALUSrc_A = 2'b10;
                PCSource = 2'b01;
                PCWrite  = branch_cond;
                case (Fun3[2:1])
                    2'b10:   ALU_Control = ALU_SLT;
                    2'b11:   ALU_Control = ALU_SLTU;
                    default: ALU_Control = ALU_SUB;
                endcase
                next_state = S_IF;
            end
            S_EX_JAL: begin
                ALUSrc_A   = 2'b01;
                ALUSrc_B   = 2'b01;
                ImmSel     = 2'b11;
                PCWrite    = 1'b1;
                RegWrite   = 1'b1;
                MemtoReg   = 2'b10;
                next_state = S_IF;
            end
            S_EX_JALR: begin
                ALUSrc_A   = 2'b10;
                ALUSrc_B   = 2'b01;
                PCSource   = 2'b10;
                PCWrite    = 1'b1;
                RegWrite   = 1'b1;
                MemtoReg   = 2'b10;
                next_state = S_IF;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_TRAP;
            end
        endcase

        if (timeout) begin
            next_state = S_TRAP;
        end
    end

endmodule
